// File: rtl/matmul_nxn_stream.sv
// Streaming NxN matrix multiplier: loads A then B row-major, runs one MAC per
// cycle over (i, j, k), then drains C row-major through a valid/ready port.
// C is kept between operations so a later run can accumulate onto it.
module matmul_nxn_stream #(
  parameter int N      = 4,
  parameter int DW     = 8,
  parameter int SIGNED = 0,
  parameter int CW     = 2*DW + $clog2(N)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          acc_en,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [CW-1:0] out_data,
  output logic          out_last,
  output logic          busy,
  output logic          done
);

  localparam int NN = N*N;
  localparam int AW = $clog2(NN);
  localparam int IW = $clog2(N);
  localparam int LW = $clog2(2*NN);

  localparam logic [IW-1:0] NM1     = IW'(N-1);
  localparam logic [AW-1:0] NA      = AW'(N);
  localparam logic [AW-1:0] NN_LAST = AW'(NN-1);
  localparam logic [LW-1:0] LD_B    = LW'(NN);
  localparam logic [LW-1:0] LD_LAST = LW'(2*NN-1);

  typedef enum logic [1:0] {IDLE, LOAD, MAC, DRAIN} state_t;
  state_t state, state_nx;

  logic [NN-1:0][DW-1:0] a_mem, b_mem;
  logic [NN-1:0][CW-1:0] c_mem;

  logic [LW-1:0] ld_cnt;
  logic [IW-1:0] mi, mj, mk;
  logic [AW-1:0] out_cnt;
  logic          acc_en_q;
  logic [CW-1:0] acc;

  logic          in_fire, out_fire, load_last, mac_last;
  logic [AW-1:0] a_addr, b_addr, c_addr;
  logic [DW-1:0] a_op, b_op;
  logic [CW-1:0] a_ext, b_ext, prod, seed, acc_sum;

  assign in_fire   = in_valid & in_ready;
  assign out_fire  = out_valid & out_ready;
  assign load_last = in_fire && (ld_cnt == LD_LAST);
  assign mac_last  = (mi == NM1) && (mj == NM1) && (mk == NM1);

  // Operand/result addressing for the current (i, j, k) step
  always_comb begin
    a_addr = mi * NA + AW'(mk);
    b_addr = mk * NA + AW'(mj);
    c_addr = mi * NA + AW'(mj);
    a_op   = a_mem[a_addr];
    b_op   = b_mem[b_addr];
  end

  // Extend operands to CW first; the low CW bits of the product then equal
  // the 2*DW product extended to CW, and the sum wraps modulo 2^CW.
  generate
    if (SIGNED != 0) begin : g_ext
      assign a_ext = {{(CW-DW){a_op[DW-1]}}, a_op};
      assign b_ext = {{(CW-DW){b_op[DW-1]}}, b_op};
    end else begin : g_ext
      assign a_ext = {{(CW-DW){1'b0}}, a_op};
      assign b_ext = {{(CW-DW){1'b0}}, b_op};
    end
  endgenerate

  // Accumulator seed on k=0 is either the stored C element or zero
  always_comb begin
    prod    = a_ext * b_ext;
    seed    = acc_en_q ? c_mem[c_addr] : '0;
    acc_sum = ((mk == '0) ? seed : acc) + prod;
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // Next-state and handshake outputs; start is only honoured in IDLE
  always_comb begin
    state_nx  = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    out_last  = 1'b0;
    out_data  = c_mem[out_cnt];
    busy      = (state != IDLE);
    case (state)
      IDLE:  if (start) state_nx = LOAD;
      LOAD: begin
        in_ready = 1'b1;
        if (load_last) state_nx = MAC;
      end
      MAC:   if (mac_last) state_nx = DRAIN;
      DRAIN: begin
        out_valid = 1'b1;
        out_last  = (out_cnt == NN_LAST);
        if (out_fire && out_last) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Operand capture; A and B need no reset since every run reloads them
  always_ff @(posedge clk) begin
    if (state == LOAD && in_fire) begin
      if (ld_cnt < LD_B) a_mem[AW'(ld_cnt)]        <= in_data;
      else               b_mem[AW'(ld_cnt - LD_B)] <= in_data;
    end
  end

  // Counters, accumulator, C storage and the done pulse
  always_ff @(posedge clk) begin
    if (rst) begin
      ld_cnt   <= '0;
      mi       <= '0;
      mj       <= '0;
      mk       <= '0;
      out_cnt  <= '0;
      acc_en_q <= 1'b0;
      acc      <= '0;
      c_mem    <= '0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (start) begin
          acc_en_q <= acc_en;
          ld_cnt   <= '0;
          mi       <= '0;
          mj       <= '0;
          mk       <= '0;
          out_cnt  <= '0;
        end
        LOAD: if (in_fire) ld_cnt <= ld_cnt + LW'(1);
        MAC: begin
          acc <= acc_sum;
          if (mk == NM1) begin
            c_mem[c_addr] <= acc_sum;
            mk <= '0;
            if (mj == NM1) begin
              mj <= '0;
              mi <= (mi == NM1) ? '0 : mi + IW'(1);
            end else begin
              mj <= mj + IW'(1);
            end
          end else begin
            mk <= mk + IW'(1);
          end
        end
        DRAIN: if (out_fire) begin
          if (out_last) done <= 1'b1;
          else          out_cnt <= out_cnt + AW'(1);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_matmul_nxn_stream.sv
// Directed bench for matmul_nxn_stream, N=4 DW=8; an unsigned and a signed
// instance share the same stimulus and run in lockstep.
module tb_matmul_nxn_stream;
  localparam int N  = 4;
  localparam int DW = 8;
  localparam int CW = 18;

  logic clk = 1'b0, rst = 1'b1, start = 1'b0, acc_en = 1'b0;
  logic in_valid = 1'b0, out_ready = 1'b1;
  logic [DW-1:0] in_data = '0;
  logic in_ready, out_valid, out_last, busy, done;
  logic [CW-1:0] out_data;
  logic s_in_ready, s_out_valid, s_out_last, s_busy, s_done;
  logic [CW-1:0] s_out_data;

  matmul_nxn_stream #(.N(N), .DW(DW), .SIGNED(0)) dut (
    .clk(clk), .rst(rst), .start(start), .acc_en(acc_en),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_last(out_last), .busy(busy), .done(done));

  matmul_nxn_stream #(.N(N), .DW(DW), .SIGNED(1)) u_s (
    .clk(clk), .rst(rst), .start(start), .acc_en(acc_en),
    .in_valid(in_valid), .in_ready(s_in_ready), .in_data(in_data),
    .out_valid(s_out_valid), .out_ready(out_ready), .out_data(s_out_data),
    .out_last(s_out_last), .busy(s_busy), .done(s_done));

  always #5 clk = ~clk;

  int checks = 0, errors = 0;
  logic [7:0]    ma [16], mb [16];
  logic [CW-1:0] c_model [16];
  logic [CW-1:0] got [16], s_got [16];
  logic          got_last [16];
  int nout, done_cnt, first_ir, first_ov, done_cyc, stall_bad, proto_bad;

  // Unsigned reference for the SIGNED=0 instance; tracks its C storage
  function automatic void model_run(input logic ae);
    logic [CW-1:0] s;
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++) begin
        s = ae ? c_model[i*4+j] : '0;
        for (int k = 0; k < 4; k++) s = s + ma[i*4+k] * mb[k*4+j];
        c_model[i*4+j] = s;
      end
  endfunction

  // One full operation; cycle c=1 is the first cycle after start is sampled
  task automatic run_op(input logic ae, input bit gaps, input bit stall, input bit glitch);
    int c, ld;
    logic [CW-1:0] hold;
    nout = 0; done_cnt = 0; first_ir = -1; first_ov = -1; done_cyc = -1;
    stall_bad = 0; proto_bad = 0; hold = '0;
    @(negedge clk); start = 1'b1; acc_en = ae; in_valid = 1'b0; out_ready = 1'b1;
    @(negedge clk); start = 1'b0; acc_en = 1'b0;
    c = 1; ld = 0;
    while (c < 3000) begin
      in_valid = (ld < 32) && (!gaps || $urandom_range(0, 2) != 0);
      if (ld < 16)      in_data = ma[ld];
      else if (ld < 32) in_data = mb[ld-16];
      else              in_data = '0;
      start = glitch && (c == 5 || c == 100);
      out_ready = !(stall && first_ov >= 0 && c >= first_ov + 3 && c < first_ov + 8);
      if (in_ready && first_ir < 0) first_ir = c;
      if (out_valid && first_ov < 0) first_ov = c;
      if (stall && first_ov >= 0 && c >= first_ov + 3 && c < first_ov + 8) begin
        if (!out_valid) stall_bad++;
        if (c == first_ov + 3) hold = out_data;
        else if (out_data !== hold) stall_bad++;
      end
      if (ld >= 32 && in_ready) proto_bad++;
      if (nout >= 16 && out_valid) proto_bad++;
      if (out_last && !out_valid) proto_bad++;
      if (s_busy !== busy || s_done !== done || s_in_ready !== in_ready ||
          s_out_valid !== out_valid || s_out_last !== out_last) proto_bad++;
      if (in_valid && in_ready) ld++;
      if (out_valid && out_ready) begin
        if (nout < 16) begin
          got[nout] = out_data; s_got[nout] = s_out_data; got_last[nout] = out_last;
        end
        nout++;
      end
      if (done) begin
        done_cnt++;
        if (done_cyc < 0) done_cyc = c;
      end
      @(negedge clk); c++;
      if (done_cyc >= 0 && c > done_cyc + 2) break;
    end
    start = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checks++; if (busy !== 1'b0)      begin errors++; $display("FAIL reset busy: got %b expected 0", busy); end
    checks++; if (in_ready !== 1'b0)  begin errors++; $display("FAIL reset in_ready: got %b expected 0", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset out_valid: got %b expected 0", out_valid); end
    checks++; if (out_last !== 1'b0)  begin errors++; $display("FAIL reset out_last: got %b expected 0", out_last); end
    checks++; if (done !== 1'b0)      begin errors++; $display("FAIL reset done: got %b expected 0", done); end
    rst = 1'b0;
    for (int i = 0; i < 16; i++) c_model[i] = '0;
  endtask

  task automatic test_identity(input bit glitch);
    for (int i = 0; i < 16; i++) begin
      ma[i] = (i / 4 == i % 4) ? 8'd1 : 8'd0;
      mb[i] = 8'(i);
    end
    run_op(1'b0, 1'b0, 1'b0, glitch);
    model_run(1'b0);
    for (int i = 0; i < 16; i++) begin
      checks++;
      if (got[i] !== CW'(i)) begin errors++; $display("FAIL identity data beat %0d (glitch=%0d): got %0d expected %0d", i, glitch, got[i], i); end
      checks++;
      if (got_last[i] !== (i == 15)) begin errors++; $display("FAIL identity last beat %0d: got %b expected %b", i, got_last[i], i == 15); end
    end
    checks++; if (nout !== 16)      begin errors++; $display("FAIL identity beats: got %0d expected 16", nout); end
    checks++; if (done_cnt !== 1)   begin errors++; $display("FAIL identity done pulses: got %0d expected 1", done_cnt); end
    checks++; if (first_ir !== 1)   begin errors++; $display("FAIL identity first in_ready cycle: got %0d expected 1", first_ir); end
    checks++; if (first_ov !== 97)  begin errors++; $display("FAIL identity first out_valid cycle: got %0d expected 97", first_ov); end
    checks++; if (done_cyc !== 113) begin errors++; $display("FAIL identity done cycle: got %0d expected 113", done_cyc); end
    checks++; if (proto_bad !== 0)  begin errors++; $display("FAIL identity protocol: got %0d violations expected 0", proto_bad); end
  endtask

  task automatic test_extremes();
    // 0xFF: unsigned 255*255*4 = 260100, signed (-1)*(-1)*4 = 4
    for (int i = 0; i < 16; i++) begin ma[i] = 8'hFF; mb[i] = 8'hFF; end
    run_op(1'b0, 1'b0, 1'b0, 1'b0);
    model_run(1'b0);
    for (int i = 0; i < 16; i++) begin
      checks++; if (got[i] !== 18'd260100) begin errors++; $display("FAIL uns_ff beat %0d: got %0d expected 260100", i, got[i]); end
      checks++; if (s_got[i] !== 18'd4)    begin errors++; $display("FAIL sgn_ff beat %0d: got %0d expected 4", i, s_got[i]); end
    end
    // 0x80: signed (-128)^2*4 = 65536, unsigned 128^2*4 = 65536
    for (int i = 0; i < 16; i++) begin ma[i] = 8'h80; mb[i] = 8'h80; end
    run_op(1'b0, 1'b0, 1'b0, 1'b0);
    model_run(1'b0);
    for (int i = 0; i < 16; i++) begin
      checks++; if (s_got[i] !== 18'h10000) begin errors++; $display("FAIL sgn_80 beat %0d: got %0d expected 65536", i, s_got[i]); end
      checks++; if (got[i] !== 18'h10000)   begin errors++; $display("FAIL uns_80 beat %0d: got %0d expected 65536", i, got[i]); end
    end
    checks++; if (done_cnt !== 1) begin errors++; $display("FAIL extremes done pulses: got %0d expected 1", done_cnt); end
  endtask

  task automatic test_accumulate();
    for (int i = 0; i < 16; i++) begin ma[i] = 8'd1; mb[i] = 8'd1; end
    run_op(1'b0, 1'b0, 1'b0, 1'b0);
    model_run(1'b0);
    for (int i = 0; i < 16; i++) begin
      checks++; if (got[i] !== 18'd4) begin errors++; $display("FAIL acc0 beat %0d: got %0d expected 4", i, got[i]); end
    end
    run_op(1'b1, 1'b0, 1'b0, 1'b0);
    model_run(1'b1);
    for (int i = 0; i < 16; i++) begin
      checks++; if (got[i] !== 18'd8) begin errors++; $display("FAIL acc1 beat %0d: got %0d expected 8", i, got[i]); end
    end
  endtask

  task automatic test_stall_gaps();
    for (int i = 0; i < 16; i++) begin
      ma[i] = 8'($urandom_range(0, 255));
      mb[i] = 8'($urandom_range(0, 255));
    end
    run_op(1'b1, 1'b1, 1'b1, 1'b0);
    model_run(1'b1);
    for (int i = 0; i < 16; i++) begin
      checks++; if (got[i] !== c_model[i]) begin errors++; $display("FAIL stall data beat %0d: got %0d expected %0d", i, got[i], c_model[i]); end
    end
    checks++; if (stall_bad !== 0) begin errors++; $display("FAIL stall hold: got %0d unstable cycles expected 0", stall_bad); end
    checks++; if (nout !== 16)     begin errors++; $display("FAIL stall beats: got %0d expected 16", nout); end
    checks++; if (done_cnt !== 1)  begin errors++; $display("FAIL stall done pulses: got %0d expected 1", done_cnt); end
    checks++; if (proto_bad !== 0) begin errors++; $display("FAIL stall protocol: got %0d violations expected 0", proto_bad); end
  endtask

  task automatic test_reset_mid_mac();
    int dseen;
    for (int i = 0; i < 16; i++) begin ma[i] = 8'd1; mb[i] = 8'd1; end
    @(negedge clk); start = 1'b1; acc_en = 1'b1;
    @(negedge clk); start = 1'b0; acc_en = 1'b0;
    for (int b = 0; b < 32; b++) begin
      in_valid = 1'b1; in_data = (b < 16) ? ma[b] : mb[b-16];
      @(negedge clk);
    end
    in_valid = 1'b0;
    repeat (10) @(negedge clk);
    rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    checks++; if (busy !== 1'b0)      begin errors++; $display("FAIL abort busy: got %b expected 0", busy); end
    checks++; if (done !== 1'b0)      begin errors++; $display("FAIL abort done: got %b expected 0", done); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL abort out_valid: got %b expected 0", out_valid); end
    dseen = 0;
    repeat (5) begin @(negedge clk); if (done) dseen++; end
    checks++; if (dseen !== 0) begin errors++; $display("FAIL abort late done: got %0d pulses expected 0", dseen); end
    for (int i = 0; i < 16; i++) c_model[i] = '0;
    run_op(1'b1, 1'b0, 1'b0, 1'b0);
    model_run(1'b1);
    for (int i = 0; i < 16; i++) begin
      checks++; if (got[i] !== 18'd4) begin errors++; $display("FAIL post-reset acc beat %0d: got %0d expected 4", i, got[i]); end
    end
  endtask

  initial begin
    test_reset();
    test_identity(1'b0);
    test_extremes();
    test_accumulate();
    test_stall_gaps();
    test_reset_mid_mac();
    test_identity(1'b1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
